// File: rtl/ecc_decoding_pipe_if.sv
// Read-lane bus for the SECDED decoder: the code word going in, and the
// corrected word with its flags coming out.
interface ecc_decoding_pipe_if;
  logic        valid_i;
  logic [38:0] code_i;
  logic        valid_o;
  logic [31:0] data_o;
  logic        sec_o;
  logic        ded_o;
  logic [5:0]  err_pos_o;

  // Read mux / stimulus side
  modport master (
    output valid_i,
    output code_i,
    input  valid_o,
    input  data_o,
    input  sec_o,
    input  ded_o,
    input  err_pos_o
  );

  // Decoder side
  modport slave (
    input  valid_i,
    input  code_i,
    output valid_o,
    output data_o,
    output sec_o,
    output ded_o,
    output err_pos_o
  );
endinterface

// File: rtl/ecc_decoding_pipe.sv
// Pipelined SECDED (39,32) decoder for one block-RAM read lane.
//
// Code word layout: [31:0] data, [37:32] Hamming check bits, [38] overall
// parity. Data bit k occupies the k-th non-power-of-two Hamming position in
// 1..38 (3,5,6,7,9,...); check bit j covers every data bit whose Hamming
// position has bit j set. A non-zero syndrome is therefore the Hamming
// position of a single flipped bit: a power of two names a check bit, any
// other value up to 38 names a data bit, and 39..63 is uncorrectable.
//
// Optional macro ECC_DECODE_OUTREG_EN adds a register stage after decode
// (latency 2 instead of 1); the error counters and status FSM follow the
// registered outputs so they stay aligned with valid_o.
module ecc_decoding_pipe #(
  parameter int CNT_W = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               cfg_ecc_enable_i,
  input  logic               clear_i,
  ecc_decoding_pipe_if.slave bus,
  output logic [CNT_W-1:0]   sec_cnt_o,
  output logic [CNT_W-1:0]   ded_cnt_o,
  output logic [1:0]         status_o
);

  localparam logic [1:0]       ST_OK        = 2'd0;
  localparam logic [1:0]       ST_CORRECTED = 2'd1;
  localparam logic [1:0]       ST_FAILED    = 2'd2;
  localparam logic [5:0]       PARITY_POS   = 6'd38;
  localparam logic [CNT_W-1:0] CNT_MAX      = '1;

  // Hamming position (1..38) that carries data bit idx.
  function automatic logic [5:0] data_hpos(input int idx);
    logic [5:0] pos;
    int         n;
    pos = '0;
    n   = 0;
    for (int p = 1; p < 39; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (n == idx) pos = 6'(p);
        n++;
      end
    end
    return pos;
  endfunction

  // Check bits the encoder would have produced for this data word.
  function automatic logic [5:0] calc_check(input logic [31:0] d);
    logic [5:0] chk;
    logic [5:0] hp;
    chk = '0;
    for (int i = 0; i < 32; i++) begin
      hp = data_hpos(i);
      for (int j = 0; j < 6; j++) begin
        if (hp[j]) chk[j] = chk[j] ^ d[i];
      end
    end
    return chk;
  endfunction

  // ---------------------------------------------------------------------
  // Stage 1: input register
  // ---------------------------------------------------------------------
  logic        valid_s1_d, valid_s1_q;
  logic [38:0] code_s1_d,  code_s1_q;

  // Capture the valid strobe every cycle; hold the code word between reads.
  always_comb begin
    valid_s1_d = bus.valid_i;
    code_s1_d  = bus.valid_i ? bus.code_i : code_s1_q;
  end

  // Stage-1 flops.
  // NOTE: the code register is reset too, so data_o reads 0 out of reset
  // rather than whatever the flops powered up with.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_s1_q <= 1'b0;
      code_s1_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples the values
      // from before the edge, independent of statement order.
      valid_s1_q <= valid_s1_d;
      code_s1_q  <= code_s1_d;
    end
  end

  // ---------------------------------------------------------------------
  // Decode and classification (combinational on stage 1)
  // ---------------------------------------------------------------------
  logic [5:0]  syndrome;
  logic        parity_err;
  logic        chk_hit;
  logic [5:0]  chk_pos;
  logic        data_hit;
  logic [5:0]  data_pos;
  logic [31:0] data_flip;
  logic        dec_valid;
  logic [31:0] dec_data;
  logic        dec_sec;
  logic        dec_ded;
  logic [5:0]  dec_pos;

  // Syndrome, overall parity, and the SEC/DED decision for the stage-1 word.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves
    // one unassigned, which would otherwise infer a latch.
    syndrome   = calc_check(code_s1_q[31:0]) ^ code_s1_q[37:32];
    parity_err = ^code_s1_q;
    chk_hit    = 1'b0;
    chk_pos    = '0;
    data_hit   = 1'b0;
    data_pos   = '0;
    data_flip  = '0;
    dec_valid  = valid_s1_q;
    dec_data   = code_s1_q[31:0];
    dec_sec    = 1'b0;
    dec_ded    = 1'b0;
    dec_pos    = '0;

    // A single-bit syndrome points at one of the stored check bits.
    for (int j = 0; j < 6; j++) begin
      if (syndrome == 6'(1 << j)) begin
        chk_hit = 1'b1;
        chk_pos = 6'(32 + j);
      end
    end

    // Any other legal syndrome points at a data bit.
    for (int i = 0; i < 32; i++) begin
      if (data_hpos(i) == syndrome) begin
        data_hit     = 1'b1;
        data_pos     = 6'(i);
        data_flip[i] = 1'b1;
      end
    end

    // Flags only exist for valid words with decoding enabled; in bypass the
    // raw data goes straight through and the counters/FSM see no events.
    if (valid_s1_q && cfg_ecc_enable_i) begin
      if (!parity_err) begin
        // Even number of flips: either clean or an uncorrectable pair.
        dec_ded = (syndrome != 6'd0);
      end else if (syndrome == 6'd0) begin
        // Only the overall parity bit itself is wrong.
        dec_sec = 1'b1;
        dec_pos = PARITY_POS;
      end else if (chk_hit) begin
        // A check bit flipped; the data is already correct.
        dec_sec = 1'b1;
        dec_pos = chk_pos;
      end else if (data_hit) begin
        dec_sec  = 1'b1;
        dec_pos  = data_pos;
        dec_data = code_s1_q[31:0] ^ data_flip;
      end else begin
        // Odd parity but the syndrome names no real bit: at least three flips.
        dec_ded = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Output stage
  // ---------------------------------------------------------------------
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_sec;
  logic        out_ded;
  logic [5:0]  out_pos;

`ifdef ECC_DECODE_OUTREG_EN
  logic        out_valid_d, out_valid_q;
  logic [31:0] out_data_d,  out_data_q;
  logic        out_sec_d,   out_sec_q;
  logic        out_ded_d,   out_ded_q;
  logic [5:0]  out_pos_d,   out_pos_q;

  // Forward the decode result into the output register.
  always_comb begin
    out_valid_d = dec_valid;
    out_data_d  = dec_data;
    out_sec_d   = dec_sec;
    out_ded_d   = dec_ded;
    out_pos_d   = dec_pos;
  end

  // Output register: breaks the syndrome/correct path from the pins.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sec_q   <= 1'b0;
      out_ded_q   <= 1'b0;
      out_pos_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sec_q   <= out_sec_d;
      out_ded_q   <= out_ded_d;
      out_pos_q   <= out_pos_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sec   = out_sec_q;
  assign out_ded   = out_ded_q;
  assign out_pos   = out_pos_q;
`else
  assign out_valid = dec_valid;
  assign out_data  = dec_data;
  assign out_sec   = dec_sec;
  assign out_ded   = dec_ded;
  assign out_pos   = dec_pos;
`endif

  assign bus.valid_o   = out_valid;
  assign bus.data_o    = out_data;
  assign bus.sec_o     = out_sec;
  assign bus.ded_o     = out_ded;
  assign bus.err_pos_o = out_pos;

  // ---------------------------------------------------------------------
  // Error counters and sticky status
  // ---------------------------------------------------------------------
  logic             ev_sec;
  logic             ev_ded;
  logic [CNT_W-1:0] sec_cnt_d, sec_cnt_q;
  logic [CNT_W-1:0] ded_cnt_d, ded_cnt_q;
  logic [1:0]       status_d,  status_q;

  // Events are taken from the word currently presented on the outputs.
  assign ev_sec = out_valid & out_sec;
  assign ev_ded = out_valid & out_ded;

  // Saturating counters; a clear restarts them at the current event so the
  // event that coincides with the clear is never lost.
  always_comb begin
    sec_cnt_d = sec_cnt_q;
    ded_cnt_d = ded_cnt_q;
    if (clear_i) begin
      sec_cnt_d = CNT_W'(ev_sec);
      ded_cnt_d = CNT_W'(ev_ded);
    end else begin
      if (ev_sec && (sec_cnt_q != CNT_MAX)) sec_cnt_d = sec_cnt_q + 1'b1;
      if (ev_ded && (ded_cnt_q != CNT_MAX)) ded_cnt_d = ded_cnt_q + 1'b1;
    end
  end

  // Status FSM: OK -> CORRECTED on SEC, anything but FAILED -> FAILED on DED;
  // a clear restarts from OK and then applies the current event.
  always_comb begin
    status_d = status_q;
    if (clear_i) begin
      if (ev_ded)      status_d = ST_FAILED;
      else if (ev_sec) status_d = ST_CORRECTED;
      else             status_d = ST_OK;
    end else begin
      case (status_q)
        ST_OK: begin
          if (ev_ded)      status_d = ST_FAILED;
          else if (ev_sec) status_d = ST_CORRECTED;
        end
        ST_CORRECTED: begin
          if (ev_ded) status_d = ST_FAILED;
        end
        ST_FAILED: status_d = ST_FAILED;
        default:   status_d = ST_OK;
      endcase
    end
  end

  // Counter and status flops.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sec_cnt_q <= '0;
      ded_cnt_q <= '0;
      status_q  <= ST_OK;
    end else begin
      sec_cnt_q <= sec_cnt_d;
      ded_cnt_q <= ded_cnt_d;
      status_q  <= status_d;
    end
  end

  assign sec_cnt_o = sec_cnt_q;
  assign ded_cnt_o = ded_cnt_q;
  assign status_o  = status_q;

endmodule
